axi_lite_selftest_master: RTL and testbench



---
 rtl/axi_lite_selftest_master.sv | 224 ++++++++++++++++++++++
 tb/tb_axi_lite_selftest_master.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_selftest_master.sv
// AXI4-Lite self-test master: writes a rotating pattern to C_NUM_REGS registers, reads each back, counts errors.
// Optional error capture ports (err_addr/err_exp/err_act) are enabled by defining AXI_LITE_SELFTEST_ERRLOG_EN.
module axi_lite_selftest_master #(
    parameter int                        C_ADDR_WIDTH = 32,
    parameter int                        C_DATA_WIDTH = 32,
    parameter logic [C_ADDR_WIDTH-1:0]   C_BASE_ADDR  = '0,
    parameter int                        C_NUM_REGS   = 4,
    parameter logic [C_DATA_WIDTH-1:0]   C_SEED       = C_DATA_WIDTH'(32'h0101FFFF)
) (
    input  logic                        ACLK,
    input  logic                        ARESETN,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [15:0]                 err_count,
    output logic [C_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                  M_AXI_AWPROT,
    output logic                        M_AXI_AWVALID,
    input  logic                        M_AXI_AWREADY,
    output logic [C_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                        M_AXI_WVALID,
    input  logic                        M_AXI_WREADY,
    input  logic [1:0]                  M_AXI_BRESP,
    input  logic                        M_AXI_BVALID,
    output logic                        M_AXI_BREADY,
    output logic [C_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                  M_AXI_ARPROT,
    output logic                        M_AXI_ARVALID,
    input  logic                        M_AXI_ARREADY,
    input  logic [C_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                  M_AXI_RRESP,
    input  logic                        M_AXI_RVALID,
    output logic                        M_AXI_RREADY
`ifdef AXI_LITE_SELFTEST_ERRLOG_EN
    ,
    output logic [C_ADDR_WIDTH-1:0]     err_addr,
    output logic [C_DATA_WIDTH-1:0]     err_exp,
    output logic [C_DATA_WIDTH-1:0]     err_act
`endif
);

    localparam int BYTE_SHIFT = $clog2(C_DATA_WIDTH / 8);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
        S_WRESP = 3'd2,
        S_RD    = 3'd3,
        S_RDATA = 3'd4,
        S_NEXT  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t                    state_q, state_d;
    logic [8:0]                i_q, i_d;
    logic [C_DATA_WIDTH-1:0]   pattern_q, pattern_d;
    logic [15:0]               err_count_q, err_count_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;

    logic                      start_ok;
    logic                      aw_hs, w_hs, ar_hs;
    logic                      wr_complete;
    logic                      last_reg;
    logic                      read_fail;
    logic [C_ADDR_WIDTH-1:0]   reg_addr;

    assign start_ok    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign aw_hs       = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs        = M_AXI_WVALID && M_AXI_WREADY;
    assign ar_hs       = M_AXI_ARVALID && M_AXI_ARREADY;
    assign wr_complete = (aw_done_q || aw_hs) && (w_done_q || w_hs);
    assign last_reg    = (i_q == 9'(C_NUM_REGS - 1));
    // A bad response and a data mismatch in one beat still count as a single error.
    assign read_fail   = (M_AXI_RRESP != 2'b00) || (M_AXI_RDATA != pattern_q);
    assign reg_addr    = C_BASE_ADDR + (C_ADDR_WIDTH'(i_q) << BYTE_SHIFT);

    // State register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            pattern_q   <= C_SEED;
            err_count_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            pattern_q   <= pattern_d;
            err_count_q <= err_count_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start_ok)     state_d = S_WR;
            S_WR:           if (wr_complete)  state_d = S_WRESP;
            S_WRESP:        if (M_AXI_BVALID) state_d = S_RD;
            S_RD:           if (ar_hs)        state_d = S_RDATA;
            S_RDATA:        if (M_AXI_RVALID) state_d = S_NEXT;
            S_NEXT:         state_d = last_reg ? S_DONE : S_WR;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        i_d         = i_q;
        pattern_d   = pattern_q;
        err_count_d = err_count_q;
        busy_d      = busy_q;
        done_d      = done_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        if (start_ok) begin
            i_d         = '0;
            pattern_d   = C_SEED;
            err_count_d = '0;
            busy_d      = 1'b1;
            done_d      = 1'b0;
            aw_done_d   = 1'b0;
            w_done_d    = 1'b0;
        end
        case (state_q)
            S_WR: begin
                aw_done_d = (aw_done_q || aw_hs) && !wr_complete;
                w_done_d  = (w_done_q || w_hs) && !wr_complete;
            end
            S_WRESP: begin
                if (M_AXI_BVALID && (M_AXI_BRESP != 2'b00) && (err_count_q != 16'hFFFF))
                    err_count_d = err_count_q + 16'd1;
            end
            S_RDATA: begin
                if (M_AXI_RVALID && read_fail && (err_count_q != 16'hFFFF))
                    err_count_d = err_count_q + 16'd1;
            end
            S_NEXT: begin
                pattern_d = {pattern_q[C_DATA_WIDTH-2:0], pattern_q[C_DATA_WIDTH-1]};
                i_d       = i_q + 9'd1;
                if (last_reg) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output logic: every handshake signal is a pure function of state and the per-channel done flags.
    always_comb begin
        M_AXI_AWADDR  = reg_addr;
        M_AXI_AWPROT  = 3'b000;
        M_AXI_AWVALID = (state_q == S_WR) && !aw_done_q;
        M_AXI_WDATA   = pattern_q;
        M_AXI_WSTRB   = '1;
        M_AXI_WVALID  = (state_q == S_WR) && !w_done_q;
        M_AXI_BREADY  = (state_q == S_WRESP);
        M_AXI_ARADDR  = reg_addr;
        M_AXI_ARPROT  = 3'b000;
        M_AXI_ARVALID = (state_q == S_RD);
        M_AXI_RREADY  = (state_q == S_RDATA);
        busy          = busy_q;
        done          = done_q;
        pass          = done_q && (err_count_q == 16'd0);
        err_count     = err_count_q;
    end

`ifdef AXI_LITE_SELFTEST_ERRLOG_EN
    logic                      logged_q, logged_d;
    logic [C_ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;
    logic [C_DATA_WIDTH-1:0]   err_exp_q, err_exp_d;
    logic [C_DATA_WIDTH-1:0]   err_act_q, err_act_d;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            logged_q   <= 1'b0;
            err_addr_q <= '0;
            err_exp_q  <= '0;
            err_act_q  <= '0;
        end else begin
            logged_q   <= logged_d;
            err_addr_q <= err_addr_d;
            err_exp_q  <= err_exp_d;
            err_act_q  <= err_act_d;
        end
    end

    // Only the first failing read beat of a pass is captured; write-response errors are not logged.
    always_comb begin
        logged_d   = logged_q;
        err_addr_d = err_addr_q;
        err_exp_d  = err_exp_q;
        err_act_d  = err_act_q;
        if (start_ok) begin
            logged_d   = 1'b0;
            err_addr_d = '0;
            err_exp_d  = '0;
            err_act_d  = '0;
        end else if ((state_q == S_RDATA) && M_AXI_RVALID && read_fail && !logged_q) begin
            logged_d   = 1'b1;
            err_addr_d = reg_addr;
            err_exp_d  = pattern_q;
            err_act_d  = M_AXI_RDATA;
        end
    end

    assign err_addr = err_addr_q;
    assign err_exp  = err_exp_q;
    assign err_act  = err_act_q;
`endif

endmodule

// File: tb/tb_axi_lite_selftest_master.sv
// Self-checking bench for axi_lite_selftest_master: behavioural memory slave with stall and fault
// injection, plus a pattern/error-count reference model derived from the register-test rules.
module tb_axi_lite_selftest_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int N  = 4;
    localparam logic [DW-1:0] SEED = 32'h0101FFFF;

    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    logic start = 1'b0;
    logic busy, done, pass;
    logic [15:0] err_count;
    logic [AW-1:0] AWADDR, ARADDR;
    logic [2:0] AWPROT, ARPROT;
    logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
    logic [DW-1:0] WDATA, RDATA;
    logic [DW/8-1:0] WSTRB;
    logic [1:0] BRESP, RRESP;
`ifdef AXI_LITE_SELFTEST_ERRLOG_EN
    logic [AW-1:0] err_addr;
    logic [DW-1:0] err_exp, err_act;
`endif

    int errors = 0;
    int checks = 0;

    always #5 ACLK = ~ACLK;

    axi_lite_selftest_master #(
        .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_BASE_ADDR('0), .C_NUM_REGS(N), .C_SEED(SEED)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count),
        .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
        .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
        .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
        .M_AXI_ARADDR(ARADDR), .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
        .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
`ifdef AXI_LITE_SELFTEST_ERRLOG_EN
        , .err_addr(err_addr), .err_exp(err_exp), .err_act(err_act)
`endif
    );

    // ---------------- behavioural slave ----------------
    int aw_delay = 0;
    int w_delay  = 0;
    bit bad_b [N];
    bit bad_r [N];
    bit bad_d [N];
    logic [DW-1:0] mem [N];
    int aw_cnt, w_cnt;
    logic aw_got, w_got;
    logic [AW-1:0] aw_a;
    logic [DW-1:0] w_d;
    logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [AW-1:0] p_awaddr, p_araddr;
    logic [DW-1:0] p_wdata;
    int proto_viol = 0;
    int aw_only_cnt = 0;
    int w_only_cnt = 0;
    logic [AW-1:0] wr_addr_q [$];
    logic [DW-1:0] wr_data_q [$];
    logic [AW-1:0] rd_addr_q [$];

    assign AWREADY = AWVALID && (aw_cnt >= aw_delay);
    assign WREADY  = WVALID && (w_cnt >= w_delay);
    assign ARREADY = ARVALID;

    function automatic int ridx(input logic [AW-1:0] a);
        return int'(a[AW-1:2]) % N;
    endfunction

    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            BVALID <= 1'b0; BRESP <= 2'b00; RVALID <= 1'b0; RRESP <= 2'b00; RDATA <= '0;
            p_awv <= 1'b0; p_awr <= 1'b0; p_wv <= 1'b0; p_wr <= 1'b0; p_arv <= 1'b0; p_arr <= 1'b0;
        end else begin
            // A VALID that was not accepted must stay high with stable payload.
            if ((p_awv && !p_awr && (!AWVALID || AWADDR != p_awaddr)) ||
                (p_wv && !p_wr && (!WVALID || WDATA != p_wdata)) ||
                (p_arv && !p_arr && (!ARVALID || ARADDR != p_araddr)) ||
                (AWVALID && (AWPROT != 3'b000 || WSTRB != '1)))
                proto_viol <= proto_viol + 1;
            p_awv <= AWVALID; p_awr <= AWREADY; p_awaddr <= AWADDR;
            p_wv <= WVALID; p_wr <= WREADY; p_wdata <= WDATA;
            p_arv <= ARVALID; p_arr <= ARREADY; p_araddr <= ARADDR;
            if (AWVALID && !WVALID) aw_only_cnt <= aw_only_cnt + 1;
            if (WVALID && !AWVALID) w_only_cnt <= w_only_cnt + 1;

            if (AWVALID && AWREADY) begin
                aw_got <= 1'b1; aw_a <= AWADDR; aw_cnt <= 0; wr_addr_q.push_back(AWADDR);
            end else if (AWVALID) aw_cnt <= aw_cnt + 1;
            if (WVALID && WREADY) begin
                w_got <= 1'b1; w_d <= WDATA; w_cnt <= 0; wr_data_q.push_back(WDATA);
            end else if (WVALID) w_cnt <= w_cnt + 1;

            if (BVALID && BREADY) BVALID <= 1'b0;
            if ((aw_got || (AWVALID && AWREADY)) && (w_got || (WVALID && WREADY))) begin
                mem[ridx(AWVALID && AWREADY ? AWADDR : aw_a)] <= (WVALID && WREADY) ? WDATA : w_d;
                BVALID <= 1'b1;
                BRESP  <= bad_b[ridx(AWVALID && AWREADY ? AWADDR : aw_a)] ? 2'b10 : 2'b00;
                aw_got <= 1'b0; w_got <= 1'b0;
                $display("wr addr=%h data=%h", (AWVALID && AWREADY) ? AWADDR : aw_a,
                         (WVALID && WREADY) ? WDATA : w_d);
            end

            if (RVALID && RREADY) RVALID <= 1'b0;
            if (ARVALID && ARREADY) begin
                rd_addr_q.push_back(ARADDR);
                RVALID <= 1'b1;
                RDATA  <= bad_d[ridx(ARADDR)] ? '0 : mem[ridx(ARADDR)];
                RRESP  <= bad_r[ridx(ARADDR)] ? 2'b10 : 2'b00;
                $display("rd addr=%h", ARADDR);
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] model_pattern(input int k);
        return (SEED << k) | (SEED >> (DW - k));
    endfunction

    function automatic int model_errors();
        int e = 0;
        for (int k = 0; k < N; k++) e += int'(bad_b[k]) + int'(bad_r[k] || bad_d[k]);
        return e;
    endfunction

    task automatic clear_faults();
        for (int k = 0; k < N; k++) begin bad_b[k] = 0; bad_r[k] = 0; bad_d[k] = 0; end
        aw_delay = 0; w_delay = 0;
    endtask

    // Pulses start, optionally issues a stray start while busy, waits for done (bounded).
    task automatic run_pass(input bit stray, output int cycles);
        start = 1'b1;
        @(posedge ACLK); #1;
        start = 1'b0;
        cycles = 1;
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++;
            $display("FAIL start_accept busy=%b done=%b required busy=1 done=0", busy, done); end
        while (!done && cycles < 500) begin
            if (stray && cycles == 5) start = 1'b1;
            @(posedge ACLK); #1;
            start = 1'b0;
            cycles++;
        end
        checks++; if (done !== 1'b1) begin errors++;
            $display("FAIL done_timeout cycles=%0d required done=1", cycles); end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        ARESETN = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        checks++; if ({busy, done, pass} !== 3'b000) begin errors++;
            $display("FAIL reset_status busy/done/pass=%b required 000", {busy, done, pass}); end
        checks++; if (err_count !== 16'd0) begin errors++;
            $display("FAIL reset_err_count got=%0d required 0", err_count); end
        checks++; if ({AWVALID, WVALID, BREADY, ARVALID, RREADY} !== 5'b0) begin errors++;
            $display("FAIL reset_handshake got=%b required 00000", {AWVALID, WVALID, BREADY, ARVALID, RREADY}); end
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
            $display("FAIL idle_after_reset busy=%b done=%b required 0 0", busy, done); end
    endtask

    task automatic test_basic();
        logic [DW-1:0] exp_tbl [N];
        int cycles, wb, rb;
        exp_tbl[0] = 32'h0101FFFF; exp_tbl[1] = 32'h0203FFFE;
        exp_tbl[2] = 32'h0407FFFC; exp_tbl[3] = 32'h080FFFF8;
        clear_faults();
        wb = wr_addr_q.size(); rb = rd_addr_q.size();
        run_pass(1'b0, cycles);
        checks++; if (cycles != 5 * N + 1) begin errors++;
            $display("FAIL basic_latency cycles=%0d required %0d", cycles, 5 * N + 1); end
        checks++; if (wr_addr_q.size() - wb != N || rd_addr_q.size() - rb != N) begin errors++;
            $display("FAIL basic_beats wr=%0d rd=%0d required %0d", wr_addr_q.size() - wb, rd_addr_q.size() - rb, N); end
        for (int k = 0; k < N && wb + k < wr_data_q.size() && rb + k < rd_addr_q.size(); k++) begin
            checks++;
            if (wr_addr_q[wb + k] !== AW'(4 * k) || wr_data_q[wb + k] !== exp_tbl[k] || rd_addr_q[rb + k] !== AW'(4 * k)) begin
                errors++;
                $display("FAIL basic_beat%0d wa=%h wd=%h ra=%h required addr=%h data=%h", k,
                         wr_addr_q[wb + k], wr_data_q[wb + k], rd_addr_q[rb + k], 4 * k, exp_tbl[k]);
            end
        end
        checks++; if (pass !== 1'b1 || err_count !== 16'd0 || busy !== 1'b0) begin errors++;
            $display("FAIL basic_result pass=%b err=%0d busy=%b required 1 0 0", pass, err_count, busy); end
        repeat (3) @(posedge ACLK); #1;
        checks++; if (done !== 1'b1 || pass !== 1'b1) begin errors++;
            $display("FAIL basic_done_held done=%b pass=%b required 1 1", done, pass); end
    endtask

    task automatic test_corrupt_read();
        int cycles;
        clear_faults();
        bad_d[2] = 1;
        run_pass(1'b0, cycles);
        checks++; if (err_count !== 16'd1 || pass !== 1'b0) begin errors++;
            $display("FAIL corrupt_result err=%0d pass=%b required 1 0", err_count, pass); end
`ifdef AXI_LITE_SELFTEST_ERRLOG_EN
        checks++; if (err_addr !== AW'(8) || err_exp !== 32'h0407FFFC || err_act !== '0) begin errors++;
            $display("FAIL corrupt_errlog addr=%h exp=%h act=%h required 8 0407fffc 0", err_addr, err_exp, err_act); end
`endif
    endtask

    task automatic test_stall();
        int cycles, wb, ao, wo;
        for (int dir = 0; dir < 2; dir++) begin
            clear_faults();
            aw_delay = (dir == 0) ? 0 : 3;
            w_delay  = (dir == 0) ? 3 : 0;
            wb = wr_addr_q.size(); ao = aw_only_cnt; wo = w_only_cnt;
            run_pass(1'b0, cycles);
            @(posedge ACLK); #1;
            checks++; if (wr_addr_q.size() - wb != N || wr_data_q.size() - wb != N) begin errors++;
                $display("FAIL stall%0d_beats aw=%0d w=%0d required %0d", dir, wr_addr_q.size() - wb, wr_data_q.size() - wb, N); end
            checks++;
            if ((dir == 0 && w_only_cnt - wo != 3 * N) || (dir == 1 && aw_only_cnt - ao != 3 * N)) begin errors++;
                $display("FAIL stall%0d_independent aw_only=%0d w_only=%0d required %0d", dir, aw_only_cnt - ao, w_only_cnt - wo, 3 * N); end
            checks++; if (pass !== 1'b1 || proto_viol != 0) begin errors++;
                $display("FAIL stall%0d_result pass=%b viol=%0d required 1 0", dir, pass, proto_viol); end
        end
    endtask

    task automatic test_resp_err();
        int cycles;
        clear_faults();
        bad_b[1] = 1; bad_r[1] = 1;
        run_pass(1'b0, cycles);
        checks++; if (err_count !== 16'd2 || pass !== 1'b0) begin errors++;
            $display("FAIL resp_err_result err=%0d pass=%b required 2 0", err_count, pass); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int cycles, wb;
        clear_faults();
        start = 1'b1;
        @(posedge ACLK); #1;
        start = 1'b0;
        while (!(ARVALID && ARADDR == AW'(8)) && n < 100) begin @(posedge ACLK); #1; n++; end
        checks++; if (!(ARVALID && ARADDR == AW'(8))) begin errors++;
            $display("FAIL mid_reach_rd2 arvalid=%b araddr=%h required 1 8", ARVALID, ARADDR); end
        ARESETN = 1'b0;
        #1;
        checks++; if ({busy, done, pass, ARVALID, AWVALID, RREADY, BREADY} !== 7'b0 || err_count !== 16'd0) begin errors++;
            $display("FAIL mid_reset_outputs flags=%b err=%0d required 0", {busy, done, pass, ARVALID, AWVALID, RREADY, BREADY}, err_count); end
        repeat (2) @(posedge ACLK); #1;
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        checks++; if (busy !== 1'b0 || ARVALID !== 1'b0) begin errors++;
            $display("FAIL mid_after_release busy=%b arvalid=%b required 0 0", busy, ARVALID); end
        wb = wr_addr_q.size();
        run_pass(1'b1, cycles);
        checks++; if (cycles != 5 * N + 1 || wr_addr_q.size() - wb != N) begin errors++;
            $display("FAIL mid_restart cycles=%0d beats=%0d required %0d %0d", cycles, wr_addr_q.size() - wb, 5 * N + 1, N); end
        checks++; if (wr_addr_q.size() <= wb || wr_addr_q[wb] !== '0 || pass !== 1'b1) begin errors++;
            $display("FAIL mid_clean_pass first_addr=%h pass=%b required 0 1", wr_addr_q.size() > wb ? wr_addr_q[wb] : '1, pass); end
    endtask

    task automatic test_random();
        int cycles, wb, rb, exp_err, first;
        for (int it = 0; it < 8; it++) begin
            clear_faults();
            aw_delay = $urandom_range(0, 3);
            w_delay  = $urandom_range(0, 3);
            for (int k = 0; k < N; k++) begin
                bad_b[k] = ($urandom_range(0, 3) == 0);
                bad_r[k] = ($urandom_range(0, 3) == 0);
                bad_d[k] = ($urandom_range(0, 3) == 0);
            end
            exp_err = model_errors();
            wb = wr_addr_q.size(); rb = rd_addr_q.size();
            run_pass(1'b0, cycles);
            checks++; if (err_count !== 16'(exp_err) || pass !== (exp_err == 0)) begin errors++;
                $display("FAIL rand%0d_result err=%0d pass=%b required %0d %0d", it, err_count, pass, exp_err, exp_err == 0); end
            checks++; if (wr_data_q.size() - wb != N || rd_addr_q.size() - rb != N || proto_viol != 0) begin errors++;
                $display("FAIL rand%0d_beats wr=%0d rd=%0d viol=%0d required %0d %0d 0", it,
                         wr_data_q.size() - wb, rd_addr_q.size() - rb, proto_viol, N, N); end
            for (int k = 0; k < N && wb + k < wr_data_q.size(); k++) begin
                checks++; if (wr_data_q[wb + k] !== model_pattern(k) || wr_addr_q[wb + k] !== AW'(4 * k)) begin errors++;
                    $display("FAIL rand%0d_wr%0d addr=%h data=%h required %h %h", it, k,
                             wr_addr_q[wb + k], wr_data_q[wb + k], 4 * k, model_pattern(k)); end
            end
            first = -1;
            for (int k = N - 1; k >= 0; k--) if (bad_r[k] || bad_d[k]) first = k;
`ifdef AXI_LITE_SELFTEST_ERRLOG_EN
            checks++;
            if (first < 0 ? (err_addr !== '0 || err_exp !== '0 || err_act !== '0)
                          : (err_addr !== AW'(4 * first) || err_exp !== model_pattern(first) ||
                             err_act !== (bad_d[first] ? '0 : model_pattern(first)))) begin
                errors++;
                $display("FAIL rand%0d_errlog addr=%h exp=%h act=%h first_bad=%0d", it, err_addr, err_exp, err_act, first);
            end
`else
            if (first >= 0) $display("rand%0d first failing read at reg %0d", it, first);
`endif
        end
    endtask

    initial begin
        clear_faults();
        test_reset();
        test_basic();
        test_corrupt_read();
        test_stall();
        test_resp_err();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
